// File: rtl/mem_write_monitor.sv
// Store-signature monitor for the data-memory write port.
// Flags a pass on a table hit or a timeout, then pulses stop after a drain.
module mem_write_monitor #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int NUM_CHK = 8,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 10000,
    parameter int DRAIN   = 10,
    localparam int IDX_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              stop,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [CNT_W-1:0]  hit_cycle,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = (DRAIN > 0) ? CNT_W'(DRAIN - 1) : '0;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [IDX_W:0]   NCHK     = (IDX_W + 1)'(NUM_CHK);

    logic              en_q   [NUM_CHK];
    logic [ADDR_W-1:0] addr_q [NUM_CHK];
    logic [DATA_W-1:0] data_q [NUM_CHK];

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcyc_q, hcyc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pass_q, pass_d;
    logic             tmo_q, tmo_d;
    logic             stop_q, stop_d;

    logic             wr;
    logic             hit;
    logic [IDX_W-1:0] hit_sel;

    // Case-equality keeps X/Z on the bus from ever producing a hit.
    assign wr = ((|memwrite) === 1'b1);

    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (wr && en_q[i] &&
                (dataadr === addr_q[i]) &&
                (writedata === data_q[i])) begin
                hit     = 1'b1;
                hit_sel = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                en_q[i]   <= 1'b0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (cfg_we && ({1'b0, cfg_idx} < NCHK)) begin
            en_q[cfg_idx]   <= cfg_en;
            addr_q[cfg_idx] <= cfg_addr;
            data_q[cfg_idx] <= cfg_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        wcnt_d  = wcnt_q;
        dcnt_d  = dcnt_q;
        hcyc_d  = hcyc_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        if (state_q != S_DONE && wr && wcnt_q != '1)
            wcnt_d = wcnt_q + ONE;
        unique case (state_q)
            S_RUN: begin
                cyc_d = cyc_q + ONE;
                if (hit) begin
                    pass_d  = 1'b1;
                    idx_d   = hit_sel;
                    hcyc_d  = cyc_q;
                    dcnt_d  = DRAIN_LD;
                    state_d = (DRAIN == 0) ? S_DONE : S_DRAIN;
                end else if (cyc_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == '0)
                    state_d = S_DONE;
                else
                    dcnt_d = dcnt_q - ONE;
            end
            default: ;
        endcase
        stop_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cyc_q   <= '0;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
            hcyc_q  <= '0;
            idx_q   <= '0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
            hcyc_q  <= hcyc_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            stop_q  <= stop_d;
        end
    end

    assign busy      = (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign timeout   = tmo_q;
    assign stop      = stop_q;
    assign hit_idx   = idx_q;
    assign hit_cycle = hcyc_q;
    assign cycle_cnt = cyc_q;
    assign wr_cnt    = wcnt_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed-vector bench for mem_write_monitor (TIMEOUT=50, DRAIN=10).
module tb_mem_write_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memwrite;
    logic [63:0] dataadr;
    logic [63:0] writedata;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic        cfg_en;
    logic [63:0] cfg_addr;
    logic [63:0] cfg_data;
    logic        busy, done, pass, timeout, stop;
    logic [2:0]  hit_idx;
    logic [31:0] hit_cycle, cycle_cnt, wr_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int stops;

    mem_write_monitor #(
        .ADDR_W(64), .DATA_W(64), .NUM_CHK(8), .CNT_W(32),
        .TIMEOUT(50), .DRAIN(10)
    ) dut (
        .clk(clk), .reset(reset),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .stop(stop), .hit_idx(hit_idx), .hit_cycle(hit_cycle),
        .cycle_cnt(cycle_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        memwrite  = 2'b00;
        dataadr   = '0;
        writedata = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_en    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic prog(input int idx, input logic en,
                        input logic [63:0] a, input logic [63:0] d);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_en   = en;
        cfg_addr = a;
        cfg_data = d;
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        memwrite  = 2'b01;
        dataadr   = a;
        writedata = d;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_tmo"}, 64'(timeout), 64'd0);
        chk({tag, "_stop"}, 64'(stop), 64'd0);
        chk({tag, "_idx"}, 64'(hit_idx), 64'd0);
        chk({tag, "_hcyc"}, 64'(hit_cycle), 64'd0);
        chk({tag, "_cyc"}, 64'(cycle_cnt), 64'd0);
        chk({tag, "_wr"}, 64'(wr_cnt), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // Basic hit on entry 2 at cycle 40, then drain and stop.
        do_reset();
        chk_reset_state("rst");
        prog(2, 1'b1, 64'd100, 64'd7);
        tick();
        idle();
        run_to(40);
        chk("cyc40", 64'(cycle_cnt), 64'd40);
        store(64'd100, 64'd7);
        tick();
        idle();
        chk("h_pass", 64'(pass), 64'd1);
        chk("h_idx", 64'(hit_idx), 64'd2);
        chk("h_hcyc", 64'(hit_cycle), 64'd40);
        chk("h_busy", 64'(busy), 64'd1);
        chk("h_done", 64'(done), 64'd0);
        chk("h_wr", 64'(wr_cnt), 64'd1);
        stops = 0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (stop) stops++;
            if (i == 9) chk("pre_done", 64'(done), 64'd0);
            if (i == 10) begin
                chk("done51", 64'(done), 64'd1);
                chk("stop51", 64'(stop), 64'd1);
                chk("busy51", 64'(busy), 64'd0);
            end
        end
        chk("stop_cnt", 64'(stops), 64'd1);
        chk("h_tmo", 64'(timeout), 64'd0);
        chk("frz_cyc", 64'(cycle_cnt), 64'd41);

        // Lowest index wins; near-miss stores; drain-time store; reset mid-drain.
        do_reset();
        prog(1, 1'b1, 64'd508, 64'd7);
        tick();
        prog(4, 1'b1, 64'd508, 64'd7);
        tick();
        idle();
        store(64'd508, 64'd6);
        tick();
        store(64'd320, 64'd7);
        tick();
        idle();
        chk("miss_pass", 64'(pass), 64'd0);
        chk("miss_wr", 64'(wr_cnt), 64'd2);
        store(64'd508, 64'd7);
        tick();
        idle();
        chk("lo_pass", 64'(pass), 64'd1);
        chk("lo_idx", 64'(hit_idx), 64'd1);
        chk("lo_hcyc", 64'(hit_cycle), 64'd4);
        prog(3, 1'b1, 64'd320, 64'd4950);
        tick();
        idle();
        store(64'd320, 64'd4950);
        tick();
        idle();
        chk("dr_idx", 64'(hit_idx), 64'd1);
        chk("dr_hcyc", 64'(hit_cycle), 64'd4);
        chk("dr_wr", 64'(wr_cnt), 64'd4);
        chk("dr_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc = 0;
        chk_reset_state("mid");
        store(64'd508, 64'd7);
        tick();
        idle();
        chk("clr_pass", 64'(pass), 64'd0);
        chk("clr_wr", 64'(wr_cnt), 64'd1);

        // Timeout with no matching store.
        do_reset();
        run_to(49);
        chk("t49_done", 64'(done), 64'd0);
        chk("t49_cyc", 64'(cycle_cnt), 64'd49);
        tick();
        chk("t_done", 64'(done), 64'd1);
        chk("t_tmo", 64'(timeout), 64'd1);
        chk("t_stop", 64'(stop), 64'd1);
        chk("t_pass", 64'(pass), 64'd0);
        chk("t_busy", 64'(busy), 64'd0);
        chk("t_cyc", 64'(cycle_cnt), 64'd50);
        tick();
        chk("t_stop2", 64'(stop), 64'd0);
        chk("t_hold", 64'(done), 64'd1);
        chk("t_cyc2", 64'(cycle_cnt), 64'd50);

        // Hit in the last cycle before timeout beats the timeout.
        do_reset();
        prog(5, 1'b1, 64'd80, 64'd1);
        tick();
        idle();
        run_to(49);
        store(64'd80, 64'd1);
        tick();
        idle();
        chk("e_pass", 64'(pass), 64'd1);
        chk("e_tmo", 64'(timeout), 64'd0);
        chk("e_idx", 64'(hit_idx), 64'd5);
        chk("e_hcyc", 64'(hit_cycle), 64'd49);
        chk("e_done", 64'(done), 64'd0);

        // Disabled entry never matches; re-enabled entry matches next cycle.
        do_reset();
        prog(0, 1'b1, 64'd200, 64'd9);
        tick();
        prog(0, 1'b0, 64'd200, 64'd9);
        tick();
        idle();
        store(64'd200, 64'd9);
        tick();
        idle();
        chk("dis_pass", 64'(pass), 64'd0);
        prog(0, 1'b1, 64'd200, 64'd9);
        store(64'd200, 64'd9);
        tick();
        idle();
        chk("same_pass", 64'(pass), 64'd0);
        store(64'd200, 64'd9);
        tick();
        idle();
        chk("en_pass", 64'(pass), 64'd1);
        chk("en_idx", 64'(hit_idx), 64'd0);
        chk("en_hcyc", 64'(hit_cycle), 64'd4);
        chk("en_wr", 64'(wr_cnt), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
